// File: rtl/seg_595_pkg.sv
// Shared types and constants for the static 6-digit 7-segment / 74HC595 display driver.
// Codes are common-anode, active-low; bit 7 is the decimal point.
package seg_595_pkg;

  localparam int FRAME_W = 14;
  localparam int SEG_W   = 8;
  localparam int SEL_W   = 6;

  localparam logic [SEL_W-1:0] SEL_ALL = 6'b111111;

  typedef logic [3:0] digit_t;

  localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [SEG_W-1:0] seg_decode(input digit_t d);
    return SEG_CODES[d];
  endfunction

  // seg[0] is shifted out last, so it lands at the top of the frame; sel fills the low bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [SEG_W-1:0] seg,
                                                     input logic [SEL_W-1:0] sel);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < SEG_W; i++) begin
      f[FRAME_W-1-i] = seg[i];
    end
    f[SEL_W-1:0] = sel;
    return f;
  endfunction

endpackage

// File: rtl/hc595_ctrl.sv
// Continuous serializer into two cascaded 74HC595s: one 14-bit frame every 56 clocks,
// shift clock at clk/4 with the rising edge mid-bit, and a one-clock latch pulse per frame.
module hc595_ctrl
  import seg_595_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic [SEG_W-1:0] seg_i,
  output logic             ds_o,
  output logic             shcp_o,
  output logic             stcp_o,
  output logic             oe_o
);

  logic [1:0]         cnt_4_q, cnt_4_d;
  logic [3:0]         cnt_bit_q, cnt_bit_d;
  logic               ds_q, ds_d;
  logic               shcp_q, shcp_d;
  logic               stcp_q, stcp_d;
  logic [FRAME_W-1:0] frame_s;

  // Bits are taken from the live segment value, so a mid-frame change only corrupts one frame.
  assign frame_s = build_frame(seg_i, sel_i);

  always_comb begin
    cnt_4_d   = cnt_4_q + 2'd1;
    cnt_bit_d = cnt_bit_q;
    ds_d      = ds_q;
    shcp_d    = shcp_q;
    stcp_d    = 1'b0;

    if (cnt_4_q == 2'd3) begin
      if (cnt_bit_q == 4'(FRAME_W - 1)) begin
        cnt_bit_d = 4'd0;
        stcp_d    = 1'b1;
      end else begin
        cnt_bit_d = cnt_bit_q + 4'd1;
      end
    end else begin
      cnt_bit_d = cnt_bit_q;
    end

    case (cnt_4_q)
      2'd0: begin
        ds_d   = frame_s[cnt_bit_q];
        shcp_d = 1'b0;
      end
      2'd2: shcp_d = 1'b1;
      default: begin
        ds_d   = ds_q;
        shcp_d = shcp_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_4_q   <= 2'd0;
      cnt_bit_q <= 4'd0;
      ds_q      <= 1'b0;
      shcp_q    <= 1'b0;
      stcp_q    <= 1'b0;
    end else begin
      cnt_4_q   <= cnt_4_d;
      cnt_bit_q <= cnt_bit_d;
      ds_q      <= ds_d;
      shcp_q    <= shcp_d;
      stcp_q    <= stcp_d;
    end
  end

  assign ds_o   = ds_q;
  assign shcp_o = shcp_q;
  assign stcp_o = stcp_q;
  // Displays stay blanked for as long as reset is held.
  assign oe_o   = rst_i;

endmodule

// File: rtl/seg_595_static.sv
// Static 6-digit display: all digits show one hex value stepping 0..F every CNT_MAX+1 clocks.
// Build option SEG_DP_EN lights the decimal point whenever the displayed value is odd.
module seg_595_static
  import seg_595_pkg::*;
#(
  parameter int CNT_MAX = 24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic ds,
  output logic shcp,
  output logic stcp,
  output logic oe
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [CW-1:0]    cnt_wait_q, cnt_wait_d;
  digit_t           data_q, data_d;
  logic [SEG_W-1:0] seg_q, seg_d;

  always_comb begin
    cnt_wait_d = cnt_wait_q + CW'(1);
    data_d     = data_q;
    if (cnt_wait_q == CW'(CNT_MAX)) begin
      cnt_wait_d = '0;
      data_d     = data_q + 4'd1;
    end else begin
      data_d     = data_q;
    end
  end

  always_comb begin
    seg_d = seg_decode(data_q);
`ifdef SEG_DP_EN
    seg_d[7] = ~data_q[0];
`else
    seg_d[7] = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_wait_q <= '0;
      data_q     <= 4'd0;
      seg_q      <= SEG_CODES[0];
    end else begin
      cnt_wait_q <= cnt_wait_d;
      data_q     <= data_d;
      seg_q      <= seg_d;
    end
  end

  hc595_ctrl u_hc595_ctrl (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .sel_i  (SEL_ALL),
    .seg_i  (seg_q),
    .ds_o   (ds),
    .shcp_o (shcp),
    .stcp_o (stcp),
    .oe_o   (oe)
  );

endmodule

// File: tb/tb_seg_595_static.sv
// Directed bench for seg_595_static with CNT_MAX=99; a behavioural pair of 595s
// (shift on shcp rise, latch on stcp rise) recovers the displayed frame.
module tb_seg_595_static;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic ds, shcp, stcp, oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] sr      = 16'h0000;
  logic [15:0] latched = 16'h0000;

  seg_595_static #(.CNT_MAX(99)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .ds      (ds),
    .shcp    (shcp),
    .stcp    (stcp),
    .oe      (oe)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge shcp) sr <= {sr[14:0], ds};
  always @(posedge stcp) latched <= sr;

`ifdef SEG_DP_EN
  localparam logic [7:0] EXP_D1 = 8'h79;
  localparam logic [7:0] EXP_DF = 8'h0E;
`else
  localparam logic [7:0] EXP_D1 = 8'hF9;
  localparam logic [7:0] EXP_DF = 8'h8E;
`endif
  localparam logic [13:0] FRAME0 = 14'h00FF;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    logic [13:0] frame0;
    frame0 = FRAME0;

    sys_rst = 1'b1;
    repeat (5) tick();
    check("rst_oe",   {15'd0, oe},   16'd1);
    check("rst_ds",   {15'd0, ds},   16'd0);
    check("rst_shcp", {15'd0, shcp}, 16'd0);
    check("rst_stcp", {15'd0, stcp}, 16'd0);

    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("rel_oe", {15'd0, oe}, 16'd0);
    cyc = 0;

    // First frame: shcp high on phases 2,3; stcp only on the 56th clock; ds follows frame bits.
    for (int n = 1; n <= 56; n++) begin
      tick();
      check("shcp_wave", {15'd0, shcp}, (((n - 1) % 4) >= 2) ? 16'd1 : 16'd0);
      check("stcp_wave", {15'd0, stcp}, (n == 56) ? 16'd1 : 16'd0);
      check("ds_bit",    {15'd0, ds},   {15'd0, frame0[((n - 1) / 4) % 14]});
    end
    check("cap_frame0", {2'b00, sr[13:0]}, 16'h3FC0);
    check("latch_sel0", {10'd0, latched[13:8]}, 16'h003F);
    check("latch_seg0", {8'd0, latched[7:0]}, 16'h00C0);

    run_to(57);
    check("stcp_low_after", {15'd0, stcp}, 16'd0);

    run_to(168);
    check("latch_seg1", {8'd0, latched[7:0]}, {8'd0, EXP_D1});
    run_to(280);
    check("latch_seg2", {8'd0, latched[7:0]}, 16'h00A4);
    run_to(1568);
    check("latch_segF", {8'd0, latched[7:0]}, {8'd0, EXP_DF});
    run_to(1680);
    check("latch_wrap0", {8'd0, latched[7:0]}, 16'h00C0);

    // Reset mid-frame, then the following frame must be a clean C0 latched on clock 56.
    run_to(1710);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick();
    tick();
    check("mrst_oe",   {15'd0, oe},   16'd1);
    check("mrst_ds",   {15'd0, ds},   16'd0);
    check("mrst_shcp", {15'd0, shcp}, 16'd0);
    check("mrst_stcp", {15'd0, stcp}, 16'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("mrel_oe", {15'd0, oe}, 16'd0);
    cyc = 0;
    run_to(55);
    check("mrst_stcp55", {15'd0, stcp}, 16'd0);
    run_to(56);
    check("mrst_stcp56", {15'd0, stcp}, 16'd1);
    check("mrst_seg",    {8'd0, latched[7:0]}, 16'h00C0);
    check("mrst_sel",    {10'd0, latched[13:8]}, 16'h003F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
